// File: rtl/toggle_bank_pkg.sv
// Shared constants and helpers for the toggle_bank button/light block.
// The optional long-press feature is enabled by defining TOGGLE_BANK_LONGPRESS_EN.
package toggle_bank_pkg;

    localparam int unsigned MODE_TOGGLE    = 0;
    localparam int unsigned MODE_MOMENTARY = 1;

    // Counter width able to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, counter debouncer and edge strobes.
// rise_c/flip_c are combinational and true in the cycle whose edge updates stable.
module btn_debounce
    import toggle_bank_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic stable,
    output logic rise_c,
    output logic flip_c
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    assign flip_c = (sync2 != stable) && (cnt == CNT_LAST);
    assign rise_c = flip_c && sync2;

    // Any sample equal to the current stable level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (flip_c) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/toggle_bank.sv
// Bank of debounced buttons driving lights in toggle or momentary mode.
// Define TOGGLE_BANK_LONGPRESS_EN to add per-channel long-press auto-off.
module toggle_bank
    import toggle_bank_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned MODE            = 0,
    parameter int unsigned LONG_CYCLES     = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] light,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] long_pulse
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("toggle_bank: N_CH out of range");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("toggle_bank: DEBOUNCE_CYCLES must be >= 1");
    end
    if (MODE > MODE_MOMENTARY) begin : g_bad_mode
        $error("toggle_bank: MODE must be 0 or 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("toggle_bank: LONG_CYCLES must be >= 1");
    end

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise_c;
    logic [N_CH-1:0] flip_c;
    logic [N_CH-1:0] long_c;
    logic [N_CH-1:0] toggle_c;
    logic [N_CH-1:0] follow_c;
    logic [N_CH-1:0] light_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn[i]),
            .stable(stable[i]),
            .rise_c(rise_c[i]),
            .flip_c(flip_c[i])
        );
    end

`ifdef TOGGLE_BANK_LONGPRESS_EN
    localparam int unsigned HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    // Hold counter saturates at LONG_CYCLES so each press fires at most once.
    for (genvar i = 0; i < N_CH; i++) begin : g_hold
        logic [HW-1:0] hold;

        assign long_c[i] = stable[i] && (hold == HOLD_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold <= '0;
            end else if (!stable[i]) begin
                hold <= '0;
            end else if (hold != HOLD_MAX) begin
                hold <= hold + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_pulse <= '0;
        end else begin
            long_pulse <= long_c;
        end
    end
`else
    assign long_c     = '0;
    assign long_pulse = '0;
`endif

    // Momentary lights take the new stable level on a change, else hold.
    assign toggle_c = light ^ rise_c;
    assign follow_c = (flip_c & ~stable) | (~flip_c & light);

    always_comb begin
        light_nxt = (MODE == MODE_MOMENTARY) ? follow_c : toggle_c;
        light_nxt = light_nxt & ~long_c;
        if (clr) begin
            light_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light       <= '0;
            press_pulse <= '0;
        end else begin
            light       <= light_nxt;
            press_pulse <= rise_c;
        end
    end

endmodule

// File: tb/tb_toggle_bank.sv
// Self-checking bench for toggle_bank: toggle and momentary instances side by side,
// directed sequences, a vector table and randomized stimulus against a reference model.
module tb_toggle_bank;

    localparam int unsigned NCH  = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned LNG  = 32;
`ifdef TOGGLE_BANK_LONGPRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clr;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] light_t, press_t, long_t;
    logic [NCH-1:0] light_m, press_m, long_m;

    toggle_bank #(.N_CH(NCH), .DEBOUNCE_CYCLES(DEB), .MODE(0), .LONG_CYCLES(LNG)) u_tog (
        .clk(clk), .rst_n(rst_n), .clr(clr), .btn(btn),
        .light(light_t), .press_pulse(press_t), .long_pulse(long_t)
    );

    toggle_bank #(.N_CH(NCH), .DEBOUNCE_CYCLES(DEB), .MODE(1), .LONG_CYCLES(LNG)) u_mom (
        .clk(clk), .rst_n(rst_n), .clr(clr), .btn(btn),
        .light(light_m), .press_pulse(press_m), .long_pulse(long_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a button level is accepted once the DEB synchronised
    // samples (each two edges old) all differ from the current accepted level.
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_st, m_lt, m_lm, m_press, m_long;
    int             m_high[NCH];

    // Observation statistics for the directed sequences.
    int             step_no;
    int             press_seen[NCH], press_at[NCH], mpress_seen[NCH];
    int             long_seen[NCH], long_at[NCH], mrise_at[NCH], mfall_at[NCH];
    logic [NCH-1:0] prev_lm;

    typedef struct {
        logic [NCH-1:0] b;
        logic           c;
        int             n;
        logic [NCH-1:0] l_t;
        logic [NCH-1:0] p;
        logic [NCH-1:0] l_m;
    } vec_t;
    vec_t tbl[10];

    logic [NCH-1:0] rb;
    logic           rc;
    int unsigned    thr;

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k <= DEB; k++) hist.push_back('0);
        m_st = '0; m_lt = '0; m_lm = '0; m_press = '0; m_long = '0;
        for (int ch = 0; ch < NCH; ch++) m_high[ch] = 0;
    endtask

    task automatic model_step(input logic [NCH-1:0] b, input logic c);
        for (int ch = 0; ch < NCH; ch++) begin
            bit accept, rise, lng;
            accept = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                if (hist[k][ch] == m_st[ch]) accept = 1'b0;
            end
            rise = accept && !m_st[ch];
            lng  = 1'b0;
            if (m_st[ch]) begin
                if (m_high[ch] < LNG) begin
                    m_high[ch]++;
                    lng = LP && (m_high[ch] == LNG);
                end
            end else begin
                m_high[ch] = 0;
            end
            if (c || lng) begin
                m_lt[ch] = 1'b0;
                m_lm[ch] = 1'b0;
            end else begin
                if (rise)   m_lt[ch] = ~m_lt[ch];
                if (accept) m_lm[ch] = ~m_st[ch];
            end
            if (accept) m_st[ch] = ~m_st[ch];
            m_press[ch] = rise;
            m_long[ch]  = lng;
        end
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic clear_stats();
        step_no = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            press_seen[ch] = 0; press_at[ch] = -1; mpress_seen[ch] = 0;
            long_seen[ch] = 0; long_at[ch] = -1; mrise_at[ch] = -1; mfall_at[ch] = -1;
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [NCH-1:0] b, input logic c);
        btn = b;
        clr = c;
        @(posedge clk);
        model_step(b, c);
        #1;
        step_no++;
        chk("light_tog", light_t, m_lt);
        chk("press_tog", press_t, m_press);
        chk("long_tog", long_t, m_long);
        chk("light_mom", light_m, m_lm);
        chk("press_mom", press_m, m_press);
        chk("long_mom", long_m, m_long);
        for (int ch = 0; ch < NCH; ch++) begin
            if (press_t[ch]) begin press_seen[ch]++; press_at[ch] = step_no; end
            if (press_m[ch]) mpress_seen[ch]++;
            if (long_t[ch]) begin long_seen[ch]++; long_at[ch] = step_no; end
            if (light_m[ch] && !prev_lm[ch]) mrise_at[ch] = step_no;
            if (!light_m[ch] && prev_lm[ch]) mfall_at[ch] = step_no;
        end
        prev_lm = light_m;
        @(negedge clk);
    endtask

    task automatic run(input logic [NCH-1:0] b, input logic c, input int n);
        for (int i = 0; i < n; i++) step(b, c);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic apply_reset(input logic [NCH-1:0] b);
        rst_n = 1'b0;
        btn   = b;
        clr   = 1'b0;
        #1;
        chk("rst_light_tog", light_t, '0);
        chk("rst_press_tog", press_t, '0);
        chk("rst_light_mom", light_m, '0);
        chk("rst_long_tog", long_t, '0);
        model_reset();
        prev_lm = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        clr   = 1'b0;
        rb    = '0;
        rc    = 1'b0;
        thr   = 0;
        @(negedge clk);
        apply_reset('0);
        clear_stats();

        // Clean press on channel 0: update exactly DEB+2 edges after first sample.
        run(4'b0001, 1'b0, 9);
        chk("s1_before", light_t, 4'b0000);
        run(4'b0001, 1'b0, 1);
        chk("s1_light", light_t, 4'b0001);
        chk("s1_press", press_t, 4'b0001);
        chk_int("s1_press_at", press_at[0], 10);
        run(4'b0001, 1'b0, 1);
        chk("s1_press_one", press_t, 4'b0000);
        run(4'b0000, 1'b0, 12);

        // Bouncing press on channel 1.
        clear_stats();
        run(4'b0010, 1'b0, 5);
        run(4'b0000, 1'b0, 1);
        run(4'b0010, 1'b0, 20);
        chk_int("s2_press_count", press_seen[1], 1);
        chk_int("s2_press_at", press_at[1], 16);
        chk("s2_light", light_t, 4'b0011);
        run(4'b0000, 1'b0, 12);

        // Long hold on channel 2.
        clear_stats();
        run(4'b0100, 1'b0, 100);
        chk_int("s3_press_count", press_seen[2], 1);
        if (LP) begin
            chk_int("s3_long_count", long_seen[2], 1);
            chk_int("s3_long_at", long_at[2], 42);
            chk("s3_light_tog", light_t, 4'b0011);
            chk("s3_light_mom", light_m, 4'b0000);
        end else begin
            chk_int("s3_long_count", long_seen[2], 0);
            chk("s3_light_tog", light_t, 4'b0111);
            chk("s3_light_mom", light_m, 4'b0100);
        end
        run(4'b0000, 1'b0, 12);

        // Press on channel 3 completing on the same edge as clr.
        clear_stats();
        run(4'b1000, 1'b0, 9);
        run(4'b1000, 1'b1, 1);
        chk("s4_light_tog", light_t, 4'b0000);
        chk("s4_press_tog", press_t, 4'b1000);
        chk("s4_light_mom", light_m, 4'b0000);
        chk("s4_press_mom", press_m, 4'b1000);
        run(4'b1000, 1'b0, 3);
        run(4'b0000, 1'b0, 12);

        // Momentary follow on channel 0, both edges.
        clear_stats();
        run(4'b0001, 1'b0, 20);
        run(4'b0000, 1'b0, 12);
        chk_int("s5_mpress_count", mpress_seen[0], 1);
        chk_int("s5_mrise_at", mrise_at[0], 10);
        chk_int("s5_mfall_at", mfall_at[0], 30);

        // Reset in the middle of a debounce count.
        run(4'b0010, 1'b0, 10);
        run(4'b0000, 1'b0, 12);
        chk("s6_pre_light", light_t, 4'b0011);
        run(4'b0001, 1'b0, 6);
        apply_reset(4'b0001);
        clear_stats();
        run(4'b0001, 1'b0, 9);
        chk_int("s6_no_early_press", press_seen[0], 0);
        run(4'b0001, 1'b0, 1);
        chk_int("s6_press_at", press_at[0], 10);
        chk("s6_light", light_t, 4'b0001);
        run(4'b0000, 1'b0, 12);
        run(4'b0001, 1'b0, 6);
        apply_reset(4'b0000);
        clear_stats();
        run(4'b0000, 1'b0, 15);
        chk_int("s6_release_no_press", press_seen[0], 0);
        chk("s6_release_light", light_t, 4'b0000);

        // Vector table from a clean reset.
        tbl[0] = '{4'b0000, 1'b0,  5, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0101, 1'b0, 10, 4'b0101, 4'b0101, 4'b0101};
        tbl[2] = '{4'b0101, 1'b0,  1, 4'b0101, 4'b0000, 4'b0101};
        tbl[3] = '{4'b0000, 1'b0, 10, 4'b0101, 4'b0000, 4'b0000};
        tbl[4] = '{4'b1110, 1'b0, 10, 4'b1011, 4'b1110, 4'b1110};
        tbl[5] = '{4'b0000, 1'b0, 10, 4'b1011, 4'b0000, 4'b0000};
        tbl[6] = '{4'b0000, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000};
        tbl[7] = '{4'b1111, 1'b0,  9, 4'b0000, 4'b0000, 4'b0000};
        tbl[8] = '{4'b1111, 1'b0,  1, 4'b1111, 4'b1111, 4'b1111};
        tbl[9] = '{4'b0000, 1'b0, 12, 4'b1111, 4'b0000, 4'b0000};
        apply_reset('0);
        for (int v = 0; v < 10; v++) begin
            run(tbl[v].b, tbl[v].c, tbl[v].n);
            chk($sformatf("tbl%0d_light_tog", v), light_t, tbl[v].l_t);
            chk($sformatf("tbl%0d_press", v), press_t, tbl[v].p);
            chk($sformatf("tbl%0d_light_mom", v), light_m, tbl[v].l_m);
        end

        // Randomized: alternate bouncy and slow phases, rare clr and resets.
        for (int s = 0; s < 3000; s++) begin
            thr = (((s / 500) % 2) == 0) ? 25 : 3;
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 99) < thr) rb[ch] = ~rb[ch];
            end
            rc = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 399) == 0) apply_reset(rb);
            step(rb, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_bank.md
TOGGLE_BANK -- requirements
Module: toggle_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button/light channels, range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive stable clock cycles required to accept a button level change, min 1.
REQ-003 SHALL have parameter MODE, default 0: 0 = toggle (press flips light), 1 = momentary (light follows debounced button).
REQ-004 SHALL have parameter LONG_CYCLES, default 50000: hold length for the long-press feature, min 1, ignored without the macro.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port clr, input, 1: synchronous clear of all lights.
REQ-008 SHALL have port btn, input, N_CH: raw asynchronous button levels, active high.
REQ-009 SHALL have port light, output, N_CH: registered light state per channel.
REQ-010 SHALL have port press_pulse, output, N_CH: one-cycle strobe per accepted press (debounced 0->1).
REQ-011 SHALL have port long_pulse, output, N_CH: one-cycle strobe per accepted long press.

Function
REQ-012 SHALL pass each btn bit through a 2-flop synchroniser (sync1, sync2) before any other use.
REQ-013 SHALL hold per channel a debounced level stable and counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
REQ-014 SHALL, at each edge with sync2==stable, set cnt to 0.
REQ-015 SHALL, at each edge with sync2!=stable, set stable<=sync2 and cnt<=0 if cnt==DEBOUNCE_CYCLES-1, else cnt<=cnt+1; any glitch back to the stable level restarts the count.
REQ-016 SHALL, at the edge where stable goes 0->1, assert press_pulse for exactly the following cycle and, in MODE 0, invert light at that same edge.
REQ-017 SHALL, in MODE 1, update light to the new stable value at the edge where stable changes.
REQ-018 SHALL make total latency from the first edge sampling btn high to the light/press_pulse update edge exactly DEBOUNCE_CYCLES+2 edges.
REQ-019 SHALL not toggle or pulse on a debounced 1->0 release.
REQ-020 SHALL, when clr is high at an edge, set every light bit to 0; clr wins over a simultaneous toggle, while press_pulse still fires.
REQ-021 SHALL keep channels fully independent; simultaneous presses on several channels all take effect in the same cycle.

Reset
REQ-022 SHALL, while rst_n is low, asynchronously force sync1, sync2, stable, cnt, light, press_pulse, long_pulse and hold counters to 0.
REQ-023 SHALL, with btn held high through reset release, count it as a new press DEBOUNCE_CYCLES+2 edges after release.

Configuration
REQ-024 SHALL, with macro TOGGLE_BANK_LONGPRESS_EN defined, keep a per-channel hold counter (clog2(LONG_CYCLES)+1 bits) incrementing each edge while stable==1, cleared when stable==0.
REQ-025 SHALL, with the macro defined, at the edge where the hold counter reaches LONG_CYCLES, force that light to 0, assert long_pulse for one cycle, and saturate so one press yields at most one long_pulse.
REQ-026 SHALL, without the macro, tie long_pulse to 0 and instantiate no hold counters.

Structure
REQ-027 SHALL place MODE_TOGGLE=0 / MODE_MOMENTARY=1 constants and a shared counter-width helper in package toggle_bank_pkg.
REQ-028 SHALL implement synchroniser, debouncer and edge detect in sub-module btn_debounce (one channel, outputs stable and rise strobe), generated N_CH times.

Verification (N_CH=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, MODE=0 unless noted)
REQ-029 SHALL cover: btn[0] 0->1 clean at edge k -> light[0]=1 and press_pulse[0] high one cycle after edge k+10; other bits unchanged.
REQ-030 SHALL cover: btn[1] bounces high 5 cycles, low 1, high 20 -> exactly one toggle, 10 edges after the last rising bounce.
REQ-031 SHALL cover: btn[2]=1 for 100 cycles with macro defined -> light[2] toggles to 1, then 0 at hold count 32, long_pulse[2] once; without macro -> light[2] stays 1, long_pulse 0.
REQ-032 SHALL cover: btn[3] press completing on the same edge as clr=1 -> light[3]=0, press_pulse[3]=1.
REQ-033 SHALL cover: MODE=1, btn[0] high 20 cycles then low -> light[0] follows with 10-edge latency on both edges, press_pulse once.
REQ-034 SHALL cover: rst_n asserted mid-count (cnt=4) -> all outputs 0 immediately, no pulse after release unless btn stays high 10 more edges.
